// File: rtl/particle_ctl.sv
// -----------------------------------------------------------------------------
// particle_ctl -- single sprite "particle" that is launched, flies under
// gravity, lands, lingers for a number of frames and disappears. The sprite
// is overlaid onto a VGA pixel stream through a 3-stage pipeline that also
// drives a 64x64 sprite ROM.
//
// Ports
//   clk60MHz                 system clock (rising edge only)
//   rst                      synchronous, active-high reset
//   launch                   single-cycle start pulse
//   launch_x/launch_y [10:0] start position (top-left), latched on launch
//   launch_vy [7:0]          signed initial vertical velocity (px/frame)
//   hcount_in/vcount_in      VGA pixel coordinates
//   hsync_in, vsync_in,
//   hblnk_in, vblnk_in       VGA timing
//   rgb_in [11:0]            background pixel
//   rom_addr [11:0]          sprite ROM address {row[5:0], col[5:0]}
//   rom_rgb [11:0]           ROM data, valid one cycle after rom_addr
//   *_out                    VGA stream delayed by exactly 3 cycles
//   busy                     high while flying or landed
//
// Configuration macro
//   PARTICLE_TRANSPARENCY_EN  when defined, in-box pixels whose ROM colour
//                             equals TRANSPARENT_RGB show the background;
//                             otherwise the sprite is an opaque 64x64 box.
// -----------------------------------------------------------------------------
module particle_ctl #(
  parameter int unsigned XSTEP           = 4,
  parameter int unsigned GRAVITY         = 1,
  parameter int unsigned GROUND_Y        = 700,
  parameter int unsigned LAND_FRAMES     = 30,
  parameter logic [11:0] TRANSPARENT_RGB = 12'hF0F
) (
  input  logic        clk60MHz,
  input  logic        rst,
  input  logic        launch,
  input  logic [10:0] launch_x,
  input  logic [10:0] launch_y,
  input  logic [7:0]  launch_vy,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [11:0] rom_addr,
  input  logic [11:0] rom_rgb,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, FLY, LAND} state_t;

  localparam logic [15:0] LAND_LAST = 16'(LAND_FRAMES - 1);

  state_t             state;
  logic [11:0]        pos_x;   // 12 bits: a flight may end just past column 1023
  logic [10:0]        pos_y;
  logic signed [7:0]  vel_y;
  logic [15:0]        land_cnt;

  // Pipeline stage registers
  logic [10:0] hcount_s1, vcount_s1, hcount_s2, vcount_s2;
  logic        hsync_s1, vsync_s1, hblnk_s1, vblnk_s1;
  logic        hsync_s2, vsync_s2, hblnk_s2, vblnk_s2;
  logic [11:0] rgb_s1, rgb_s2;
  logic        inbox_s1, inbox_s2;

  // Frame tick: rising edge of vblnk against the stage-1 copy of vblnk_in.
  logic tick;
  assign tick = vblnk_in & ~vblnk_s1;

  // ---------------------------------------------------------------------------
  // Motion update, evaluated from the current (old) values
  // ---------------------------------------------------------------------------
  logic [11:0]        next_x;
  logic signed [12:0] sum_y;
  logic [12:0]        y_nonneg;
  logic [10:0]        next_y;
  logic signed [8:0]  sum_vy;
  logic signed [7:0]  next_vy;
  logic               hit;

  // NOTE: every variable assigned in an always_comb gets a value on every
  // path (here simply by assigning each one unconditionally) so no latch is
  // inferred.
  always_comb begin
    next_x   = pos_x + 12'(XSTEP);
    sum_y    = $signed({2'b00, pos_y}) + $signed({{5{vel_y[7]}}, vel_y});
    y_nonneg = sum_y[12] ? 13'd0 : $unsigned(sum_y);
    hit      = (y_nonneg >= 13'(GROUND_Y)) || (next_x > 12'd1023);
    next_y   = (y_nonneg > 13'(GROUND_Y)) ? 11'(GROUND_Y) : y_nonneg[10:0];
    sum_vy   = $signed({vel_y[7], vel_y}) + $signed({1'b0, 8'(GRAVITY)});
    next_vy  = (sum_vy > 9'sd127) ? 8'sd127 : $signed(sum_vy[7:0]);
  end

  // ---------------------------------------------------------------------------
  // In-box test and ROM address; 12-bit compares so x+64 cannot wrap
  // ---------------------------------------------------------------------------
  logic [11:0] hx, vy12, py12, x_end, y_end;
  logic [5:0]  dx, dy;
  logic        inbox;
  logic [11:0] addr_nxt;

  always_comb begin
    hx       = {1'b0, hcount_in};
    vy12     = {1'b0, vcount_in};
    py12     = {1'b0, pos_y};
    x_end    = pos_x + 12'd64;
    y_end    = py12 + 12'd64;
    // Only the low 6 bits of the offsets are needed for the ROM address.
    dx       = hcount_in[5:0] - pos_x[5:0];
    dy       = vcount_in[5:0] - pos_y[5:0];
    inbox    = busy && (hx >= pos_x) && (hx < x_end) &&
               (vy12 >= py12) && (vy12 < y_end);
    addr_nxt = inbox ? {dy, dx} : 12'd0;
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered busy
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples the pre-edge values, which is what makes the three
  // motion updates simultaneous.
  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      pos_x    <= '0;
      pos_y    <= '0;
      vel_y    <= '0;
      land_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A tick in the launch cycle is ignored: motion starts next tick.
          if (launch) begin
            pos_x <= {1'b0, launch_x};
            pos_y <= launch_y;
            vel_y <= $signed(launch_vy);
            state <= FLY;
            busy  <= 1'b1;
          end
        end
        FLY: begin
          if (tick) begin
            pos_x <= next_x;
            pos_y <= next_y;
            vel_y <= next_vy;
            if (hit) begin
              state    <= LAND;
              land_cnt <= '0;
            end
          end
        end
        LAND: begin
          if (tick) begin
            if (land_cnt == LAND_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              land_cnt <= land_cnt + 16'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel pipeline: s1 = address/in-box, s2 = ROM data arrives, s3 = outputs
  // ---------------------------------------------------------------------------
  logic opaque;
`ifdef PARTICLE_TRANSPARENCY_EN
  assign opaque = (rom_rgb != TRANSPARENT_RGB);
`else
  assign opaque = 1'b1;
`endif

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      rom_addr   <= '0;
      inbox_s1   <= 1'b0;
      inbox_s2   <= 1'b0;
      hcount_s1  <= '0;
      vcount_s1  <= '0;
      hsync_s1   <= 1'b0;
      vsync_s1   <= 1'b0;
      hblnk_s1   <= 1'b0;
      vblnk_s1   <= 1'b0;
      rgb_s1     <= '0;
      hcount_s2  <= '0;
      vcount_s2  <= '0;
      hsync_s2   <= 1'b0;
      vsync_s2   <= 1'b0;
      hblnk_s2   <= 1'b0;
      vblnk_s2   <= 1'b0;
      rgb_s2     <= '0;
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      rom_addr   <= addr_nxt;
      inbox_s1   <= inbox;
      hcount_s1  <= hcount_in;
      vcount_s1  <= vcount_in;
      hsync_s1   <= hsync_in;
      vsync_s1   <= vsync_in;
      hblnk_s1   <= hblnk_in;
      vblnk_s1   <= vblnk_in;
      rgb_s1     <= rgb_in;

      inbox_s2   <= inbox_s1;
      hcount_s2  <= hcount_s1;
      vcount_s2  <= vcount_s1;
      hsync_s2   <= hsync_s1;
      vsync_s2   <= vsync_s1;
      hblnk_s2   <= hblnk_s1;
      vblnk_s2   <= vblnk_s1;
      rgb_s2     <= rgb_s1;

      hcount_out <= hcount_s2;
      vcount_out <= vcount_s2;
      hsync_out  <= hsync_s2;
      vsync_out  <= vsync_s2;
      hblnk_out  <= hblnk_s2;
      vblnk_out  <= vblnk_s2;
      rgb_out    <= (inbox_s2 && opaque) ? rom_rgb : rgb_s2;
    end
  end

endmodule

// File: tb/tb_particle_ctl.sv
// -----------------------------------------------------------------------------
// tb_particle_ctl -- self-checking bench for particle_ctl. A frame-level
// reference model (integer position/velocity, flight/landed flags, a queue of
// expected pipeline stages) predicts rom_addr, busy and the output stream
// every cycle; directed sequences add fixed expected values for the launch,
// addressing, landing, transparency and reset scenarios.
// -----------------------------------------------------------------------------
module tb_particle_ctl;

  localparam int XSTEP       = 4;
  localparam int GRAVITY     = 1;
  localparam int GROUND_Y    = 700;
  localparam int LAND_FRAMES = 30;

  logic        clk60MHz = 1'b0;
  logic        rst = 1'b1;
  logic        launch = 1'b0;
  logic [10:0] launch_x = '0, launch_y = '0;
  logic [7:0]  launch_vy = '0;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [11:0] rom_addr;
  logic [11:0] rom_rgb = '0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic        busy;

  particle_ctl #(
    .XSTEP(XSTEP), .GRAVITY(GRAVITY), .GROUND_Y(GROUND_Y),
    .LAND_FRAMES(LAND_FRAMES), .TRANSPARENT_RGB(12'hF0F)
  ) dut (
    .clk60MHz(clk60MHz), .rst(rst), .launch(launch),
    .launch_x(launch_x), .launch_y(launch_y), .launch_vy(launch_vy),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
    .rom_addr(rom_addr), .rom_rgb(rom_rgb),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .busy(busy)
  );

  always #5 clk60MHz = ~clk60MHz;

  // Sprite ROM: column 7 of every row holds the key colour.
  function automatic logic [11:0] rom_fn(input logic [11:0] a);
    if (a[5:0] == 6'd7) return 12'hF0F;
    return a ^ 12'h5A3;
  endfunction

  function automatic bit visible(input logic [11:0] c);
`ifdef PARTICLE_TRANSPARENCY_EN
    return c != 12'hF0F;
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk60MHz) rom_rgb <= rom_fn(rom_addr);

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [10:0] h, v;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
    logic        inbox;
    logic [11:0] addr;
  } stg_t;

  stg_t e_s1 = '0, e_s2 = '0, e_out = '0;
  bit   m_busy = 0, m_land = 0;
  int   m_x = 0, m_y = 0, m_vy = 0, m_cnt = 0;

  task automatic model_edge();
    bit tick, in_box;
    int nx, ny, h, v;
    logic [11:0] rd;
    if (rst) begin
      m_busy = 0; m_land = 0; m_x = 0; m_y = 0; m_vy = 0; m_cnt = 0;
      e_s1 = '0; e_s2 = '0; e_out = '0;
      return;
    end
    rd    = rom_fn(e_s2.addr);
    e_out = e_s2;
    e_out.rgb = (e_s2.inbox && visible(rd)) ? rd : e_s2.rgb;
    tick  = vblnk_in && !e_s1.vb;
    e_s2  = e_s1;
    h = int'(hcount_in); v = int'(vcount_in);
    in_box = m_busy && h >= m_x && h < m_x + 64 && v >= m_y && v < m_y + 64;
    e_s1.h = hcount_in; e_s1.v = vcount_in;
    e_s1.hs = hsync_in; e_s1.vs = vsync_in; e_s1.hb = hblnk_in; e_s1.vb = vblnk_in;
    e_s1.rgb = rgb_in; e_s1.inbox = in_box;
    e_s1.addr = in_box ? {6'((v - m_y) % 64), 6'((h - m_x) % 64)} : 12'd0;
    if (!m_busy) begin
      if (launch) begin
        m_busy = 1; m_land = 0;
        m_x = int'(launch_x); m_y = int'(launch_y); m_vy = int'($signed(launch_vy));
      end
    end else if (!m_land) begin
      if (tick) begin
        nx = m_x + XSTEP;
        ny = m_y + m_vy;
        if (ny < 0) ny = 0;
        m_vy = (m_vy + GRAVITY > 127) ? 127 : m_vy + GRAVITY;
        if (ny >= GROUND_Y || nx > 1023) begin
          m_land = 1; m_cnt = 0;
          if (ny > GROUND_Y) ny = GROUND_Y;
        end
        m_x = nx; m_y = ny;
      end
    end else if (tick) begin
      m_cnt++;
      if (m_cnt == LAND_FRAMES) begin m_busy = 0; m_land = 0; end
    end
  endtask

  // One clock: predict, advance, compare everything the model predicts.
  task automatic step();
    model_edge();
    @(posedge clk60MHz);
    #1;
    check("rom_addr", 64'(rom_addr), 64'(e_s1.addr));
    check("busy", 64'(busy), 64'(m_busy));
    check("timing", 64'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
          64'({e_out.h, e_out.v, e_out.hs, e_out.vs, e_out.hb, e_out.vb}));
    check("rgb_out", 64'(rgb_out), 64'(e_out.rgb));
  endtask

  task automatic random_pixel(input bit near);
    hsync_in = 1'($urandom); vsync_in = 1'($urandom); hblnk_in = 1'($urandom);
    rgb_in   = 12'($urandom);
    if (near && m_busy) begin
      hcount_in = 11'(m_x - 8 + int'($urandom_range(0, 80)));
      vcount_in = 11'(m_y - 8 + int'($urandom_range(0, 80)));
    end else begin
      hcount_in = 11'($urandom);
      vcount_in = 11'($urandom);
    end
  endtask

  // 40-cycle synthetic frame; vblnk rises at cycle 34 (one tick per frame).
  task automatic frame(input bit near, input bit rand_launch);
    for (int c = 0; c < 40; c++) begin
      vblnk_in = (c >= 34);
      random_pixel(near);
      launch = rand_launch && ($urandom_range(0, 99) == 0);
      if (launch) begin
        launch_x  = 11'($urandom_range(0, 1000));
        launch_y  = 11'($urandom_range(0, 760));
        launch_vy = 8'($urandom);
      end
      step();
    end
    launch = 1'b0;
  endtask

  task automatic do_launch(input int x, input int y, input int vy);
    launch = 1'b1; launch_x = 11'(x); launch_y = 11'(y); launch_vy = 8'(vy);
    step();
    launch = 1'b0;
  endtask

  task automatic probe(input int h, input int v);
    hcount_in = 11'(h); vcount_in = 11'(v);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int exp_x[3] = '{104, 108, 112};
  int exp_y[3] = '{195, 191, 188};

  initial begin
    do_reset();
    do_reset();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_addr", 64'(rom_addr), 64'd0);
    check("reset_rgb", 64'(rgb_out), 64'd0);

    // Idle block: pure 3-cycle delay of the stream.
    for (int f = 0; f < 4; f++) frame(1'b0, 1'b0);

    // Address and ROM latency at (100,200), no ticks.
    vblnk_in = 1'b0;
    do_launch(100, 200, 0);
    rgb_in = 12'h456;
    probe(130, 210);
    check("addr_130_210", 64'(rom_addr), 64'({6'd10, 6'd30}));
    step();
    step();
    check("rgb_from_rom", 64'(rgb_out), 64'h73D);
    probe(99, 210);
    check("addr_left_edge", 64'(rom_addr), 64'd0);
    probe(163, 263);
    check("addr_far_corner", 64'(rom_addr), 64'({6'd63, 6'd63}));
    probe(164, 210);
    check("addr_right_edge", 64'(rom_addr), 64'd0);

    // Launch coincident with a tick; motion starts on the following tick.
    do_reset();
    vblnk_in = 1'b0; step();
    vblnk_in = 1'b1;
    do_launch(100, 200, -5);
    probe(130, 210);
    check("launch_tick_pos", 64'(rom_addr), 64'({6'd10, 6'd30}));
    for (int k = 0; k < 3; k++) begin
      frame(1'b1, 1'b0);
      probe(exp_x[k] + 30, exp_y[k] + 10);
      check("fly_pos", 64'(rom_addr), 64'({6'd10, 6'd30}));
      probe(exp_x[k] - 1, exp_y[k]);
      check("fly_left", 64'(rom_addr), 64'd0);
    end

    // Landing and linger time.
    do_reset();
    vblnk_in = 1'b1;
    do_launch(300, 690, 20);
    frame(1'b1, 1'b0);
    check("landed_busy", 64'(busy), 64'd1);
    probe(305, 701);
    check("landed_pos", 64'(rom_addr), 64'({6'd1, 6'd1}));
    probe(305, 699);
    check("landed_above", 64'(rom_addr), 64'd0);

    // Key colour at column 7 of the landed sprite.
    hcount_in = 11'(304 + 7); vcount_in = 11'(703); rgb_in = 12'h123;
    step(); step(); step();
`ifdef PARTICLE_TRANSPARENCY_EN
    check("transparent", 64'(rgb_out), 64'h123);
`else
    check("transparent", 64'(rgb_out), 64'hF0F);
`endif

    for (int k = 1; k <= LAND_FRAMES; k++) begin
      frame(1'b1, 1'b0);
      check("land_busy", 64'(busy), (k < LAND_FRAMES) ? 64'd1 : 64'd0);
    end

    // Reset mid-flight, then a normal relaunch.
    do_launch(500, 300, 0);
    frame(1'b1, 1'b0);
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_addr", 64'(rom_addr), 64'd0);
    check("rst_rgb", 64'(rgb_out), 64'd0);
    check("rst_hcount", 64'(hcount_out), 64'd0);
    frame(1'b1, 1'b0);
    do_launch(200, 100, 0);
    check("relaunch_busy", 64'(busy), 64'd1);

    // Randomised flights with random launches (some ignored while busy).
    for (int f = 0; f < 120; f++) frame(1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/particle_ctl.md
PARTICLE_CTL -- requirements
Module: particle_ctl

Interface
REQ-001 Parameter XSTEP, default 4: horizontal pixels advanced per frame while flying (unsigned, 0-15).
REQ-002 Parameter GRAVITY, default 1: added to vertical velocity each frame (unsigned, 0-7).
REQ-003 Parameter GROUND_Y, default 700: landing row for the particle top edge.
REQ-004 Parameter LAND_FRAMES, default 30: frames the landed particle stays visible.
REQ-005 Parameter TRANSPARENT_RGB, default 12'hF0F: sprite key colour.
REQ-006 clk60MHz  in  1  system clock; the block uses only this clock, and all logic is clocked on its rising edge.
REQ-007 rst  in  1  reset; synchronous to clk60MHz and active-high.
REQ-008 launch  in  1  single-cycle start pulse.
REQ-009 launch_x / launch_y  in  11 each  start position (top-left) latched on launch.
REQ-010 launch_vy  in  8  signed initial vertical velocity, in px/frame, latched on launch.
REQ-011 hcount_in / vcount_in  in  11 each  VGA pixel coordinates.
REQ-012 hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  VGA timing.
REQ-013 rgb_in  in  12  background pixel.
REQ-014 rom_addr  out  12  sprite ROM address {row[5:0], col[5:0]}.
REQ-015 rom_rgb  in  12  ROM data; valid one cycle after rom_addr.
REQ-016 hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out  out  matching widths  delayed/merged VGA stream.
REQ-017 busy  out  1  high in FLY or LAND state.

Function
REQ-018 FSM states: IDLE, FLY, LAND.
REQ-019 Transitions:
  - IDLE->FLY on launch; latch x, y, vy.
  - FLY->LAND on the frame tick where updated y >= GROUND_Y or updated x > 1023; y clamps to GROUND_Y.
  - LAND->IDLE after LAND_FRAMES frame ticks.
  - A launch in FLY or LAND is ignored.
REQ-020 Frame tick: single-cycle pulse on the rising edge of vblnk_in, i.e. vblnk_in high with the previous-cycle registered value low.
REQ-021 In FLY, on each tick (all updates simultaneous, from old values): x <= x+XSTEP; y <= y+vy, saturating at 0 when the result is negative; vy <= vy+GRAVITY, saturating at +127.
REQ-022 Position registers change only on frame ticks; no mid-frame tearing.
REQ-023 Pipeline is exactly 3 cycles from input to output:
  - stage 1: register rom_addr, the in-box flag and the timing signals;
  - stage 2: ROM data arrives;
  - stage 3: registered outputs.
  - All *_out signals equal the inputs delayed 3 cycles.
REQ-024 In-box: busy and x <= hcount_in < x+64 and y <= vcount_in < y+64, computed in 12-bit arithmetic so x+64 does not wrap.
REQ-025 rom_addr = {(vcount_in-y)[5:0], (hcount_in-x)[5:0]} when in-box, else 0.
REQ-026 rgb_out = rom_rgb when the delayed in-box flag is set and the pixel is opaque (REQ-032), otherwise delayed rgb_in.
REQ-027 Launch and frame tick in the same cycle from IDLE: latch launch values; first motion update on the next tick.
REQ-028 In LAND the sprite is drawn stationary at its final position.

Reset
REQ-029 While rst is high at a clock edge, the FSM enters IDLE and busy=0.
REQ-030 Reset values:
  - x, y, vy and the frame counter = 0;
  - rom_addr = 0;
  - all *_out signals and pipeline stages = 0.
REQ-031 Reset mid-flight aborts immediately; the first frame after reset release shows no sprite.

Configuration
REQ-032 Macro PARTICLE_TRANSPARENCY_EN:
  - defined: in-box pixels whose rom_rgb equals TRANSPARENT_RGB show delayed rgb_in;
  - undefined: every in-box pixel shows rom_rgb (opaque 64x64 box).

Verification
REQ-033 Pipeline: idle block, random stream -> every *_out equals the input delayed 3 cycles; rgb_out equals rgb_in exactly.
REQ-034 Launch (100, 200, vy=-5), GRAVITY=1, XSTEP=4 -> over the next 3 ticks positions are (104,195), (108,191), (112,188); vy goes -4, -3, -2.
REQ-035 Address: particle at (100,200), pixel (130,210) -> rom_addr = {6'd10, 6'd30} one cycle after input; rgb_out = rom_rgb two cycles later.
REQ-036 Landing: launch y=690, vy=+20 -> LAND on the first tick with y=700; busy stays high for 30 ticks, then IDLE.
REQ-037 Transparency: rom_rgb=12'hF0F in-box -> rgb_out=rgb_in with the macro defined, 12'hF0F without it.
REQ-038 rst pulse during FLY -> next cycle busy=0 and all outputs 0; a launch after release is accepted normally.
